// File: rtl/time_update_seq_if.sv
// Bus between the timer-set/tick sources and the time-update sequencer.
// The slave side (sequencer) owns all calendar fields and status flags.
interface time_update_seq_if;
  logic       tick;
  logic       set_en;
  logic [2:0] set_sel;
  logic [5:0] set_val;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] date;
  logic [3:0] month;
  logic [2:0] day;
  logic [5:0] year;
  logic       busy;
  logic       done;
  logic       set_err;
  logic       ovf;

  modport slave (
    input  tick, set_en, set_sel, set_val,
    output sec, min, hour, date, month, day, year, busy, done, set_err, ovf
  );
  modport master (
    output tick, set_en, set_sel, set_val,
    input  sec, min, hour, date, month, day, year, busy, done, set_err, ovf
  );
endinterface

// File: rtl/time_update_seq.sv
// Calendar sequencer: a tick ripples carries sec->min->hour->date/day->month->year,
// one field per clock; field writes from the set path are accepted only when idle.
module time_update_seq #(
  parameter logic [2:0] RST_DAY = 3'd6
) (
  input logic             clk,
  input logic             clear,
  time_update_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEC, MIN, HOUR, DATE, MONTH, YEAR} state_e;

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d, min_q, min_d, year_q, year_d;
  logic [4:0] hour_q, hour_d, date_q, date_d;
  logic [3:0] month_q, month_d;
  logic [2:0] day_q, day_d;
  logic       pend_q, pend_d, busy_q, busy_d, done_q, done_d;
  logic       err_q, err_d, ovf_q, ovf_d;
  logic       start;

  function automatic logic [4:0] mlen(input logic [3:0] m, input logic [5:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
      4'd2:                    mlen = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 mlen = 5'd31;
    endcase
  endfunction

  // An accepted write takes priority over starting a cascade; the tick waits as pending.
  assign start = (state_q == IDLE) && (bus.tick || pend_q) && !bus.set_en;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    date_d  = date_q;
    month_d = month_q;
    day_d   = day_q;
    year_d  = year_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.tick && pend_q)      ovf_d  = 1'b1;
    else if (bus.tick && !start) pend_d = 1'b1;

    if (bus.set_en) begin
      if (state_q != IDLE) err_d = 1'b1;
      else begin
        case (bus.set_sel)
          3'd0: if (bus.set_val <= 6'd59) sec_d = bus.set_val; else err_d = 1'b1;
          3'd1: if (bus.set_val <= 6'd59) min_d = bus.set_val; else err_d = 1'b1;
          3'd2: if (bus.set_val <= 6'd23) hour_d = bus.set_val[4:0]; else err_d = 1'b1;
          3'd3: begin
            if (bus.set_val != 6'd0 && bus.set_val <= {1'b0, mlen(month_q, year_q)})
              date_d = bus.set_val[4:0];
            else err_d = 1'b1;
          end
          3'd4: begin
            if (bus.set_val != 6'd0 && bus.set_val <= 6'd12) begin
              month_d = bus.set_val[3:0];
              if (date_q > mlen(bus.set_val[3:0], year_q)) date_d = mlen(bus.set_val[3:0], year_q);
            end else err_d = 1'b1;
          end
          3'd5: if (bus.set_val <= 6'd6) day_d = bus.set_val[2:0]; else err_d = 1'b1;
          3'd6: begin
            year_d = bus.set_val;
            if (date_q > mlen(month_q, bus.set_val)) date_d = mlen(month_q, bus.set_val);
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    case (state_q)
      IDLE: if (start) begin
        state_d = SEC;
        pend_d  = 1'b0;
      end
      SEC: if (sec_q == 6'd59) begin
        sec_d = 6'd0; state_d = MIN;
      end else begin
        sec_d = sec_q + 6'd1; state_d = IDLE; done_d = 1'b1;
      end
      MIN: if (min_q == 6'd59) begin
        min_d = 6'd0; state_d = HOUR;
      end else begin
        min_d = min_q + 6'd1; state_d = IDLE; done_d = 1'b1;
      end
      HOUR: if (hour_q == 5'd23) begin
        hour_d = 5'd0; state_d = DATE;
      end else begin
        hour_d = hour_q + 5'd1; state_d = IDLE; done_d = 1'b1;
      end
      DATE: begin
        day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
        if (date_q >= mlen(month_q, year_q)) begin
          date_d = 5'd1; state_d = MONTH;
        end else begin
          date_d = date_q + 5'd1; state_d = IDLE; done_d = 1'b1;
        end
      end
      MONTH: if (month_q >= 4'd12) begin
        month_d = 4'd1; state_d = YEAR;
      end else begin
        month_d = month_q + 4'd1; state_d = IDLE; done_d = 1'b1;
      end
      YEAR: begin
        year_d = year_q + 6'd1; state_d = IDLE; done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      date_q  <= 5'd1;
      month_q <= 4'd1;
      day_q   <= RST_DAY;
      year_q  <= 6'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      date_q  <= date_d;
      month_q <= month_d;
      day_q   <= day_d;
      year_q  <= year_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sec     = sec_q;
  assign bus.min     = min_q;
  assign bus.hour    = hour_q;
  assign bus.date    = date_q;
  assign bus.month   = month_q;
  assign bus.day     = day_q;
  assign bus.year    = year_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.set_err = err_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_time_update_seq.sv
// Scoreboarded bench: expected field snapshots are queued at stimulus time and
// compared by a monitor whenever done or set_err pulses.
module tb_time_update_seq;
  logic clk = 1'b0;
  logic clear;
  time_update_seq_if bus();

  time_update_seq #(.RST_DAY(3'd6)) dut (.clk(clk), .clear(clear), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] date;
    logic [3:0] month;
    logic [2:0] day;
    logic [5:0] year;
  } snap_t;

  snap_t done_q[$];
  snap_t err_q[$];
  int checks = 0;
  int errors = 0;

  function automatic snap_t mk(int s, int mi, int h, int d, int mo, int dw, int y);
    snap_t r;
    r.sec = 6'(s); r.min = 6'(mi); r.hour = 5'(h); r.date = 5'(d);
    r.month = 4'(mo); r.day = 3'(dw); r.year = 6'(y);
    return r;
  endfunction

  function automatic snap_t cur();
    snap_t r;
    r.sec = bus.sec; r.min = bus.min; r.hour = bus.hour; r.date = bus.date;
    r.month = bus.month; r.day = bus.day; r.year = bus.year;
    return r;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_snap(string name, snap_t act, snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d d%0d m%0d w%0d y%0d expected %0d:%0d:%0d d%0d m%0d w%0d y%0d",
               name, act.hour, act.min, act.sec, act.date, act.month, act.day, act.year,
               exp.hour, exp.min, exp.sec, exp.date, exp.month, exp.day, exp.year);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check_snap("done_snapshot", cur(), done_q.pop_front());
      end
      if (bus.set_err === 1'b1) begin
        if (err_q.size() == 0) check("unexpected_set_err", 1, 0);
        else check_snap("set_err_snapshot", cur(), err_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int sel, int val);
    bus.set_en = 1'b1; bus.set_sel = 3'(sel); bus.set_val = 6'(val);
    step();
    bus.set_en = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int bcnt;
    fork monitor(); join_none
    clear = 1'b0;
    bus.tick = 1'b0; bus.set_en = 1'b0; bus.set_sel = 3'd0; bus.set_val = 6'd0;
    step(); step();
    check_snap("reset_fields", cur(), mk(0, 0, 0, 1, 1, 6, 0));
    check("reset_busy", bus.busy, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_done", bus.done, 0);
    clear = 1'b1;
    step();

    // Full cascade through YEAR: 2063-12-31 23:59:59.
    wr(4, 12); wr(3, 31); wr(2, 23); wr(1, 59); wr(0, 59); wr(6, 63);
    check_snap("preset_full", cur(), mk(59, 59, 23, 31, 12, 6, 63));
    done_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    do_tick();
    bcnt = 0;
    while (bus.busy === 1'b1 && bcnt < 50) begin
      bcnt++;
      step();
    end
    check("full_cascade_busy_cycles", bcnt, 6);
    step();

    // Leap February.
    wr(6, 24); wr(4, 2); wr(3, 28); wr(2, 23); wr(1, 59); wr(0, 59);
    done_q.push_back(mk(0, 0, 0, 29, 2, 1, 24));
    do_tick();
    wait_idle("leap");
    step();

    // Non-leap: writing year 23 with Feb 29 clamps to 28.
    wr(6, 23);
    check("year_write_clamp", bus.date, 28);
    wr(2, 23); wr(1, 59); wr(0, 59);
    done_q.push_back(mk(0, 0, 0, 1, 3, 2, 23));
    do_tick();
    wait_idle("nonleap");
    step();

    // Tick at 00:00:59 with two more ticks during the cascade.
    wr(0, 59);
    done_q.push_back(mk(0, 1, 0, 1, 3, 2, 23));
    done_q.push_back(mk(1, 1, 0, 1, 3, 2, 23));
    bus.tick = 1'b1;
    step(); step(); step();
    bus.tick = 1'b0;
    step(); step();
    wait_idle("pending");
    step();
    check("ovf_set", bus.ovf, 1);
    check_snap("after_pending", cur(), mk(1, 1, 0, 1, 3, 2, 23));

    // Write validation.
    wr(3, 31);
    wr(4, 4);
    check("month_write_clamp", bus.date, 30);
    err_q.push_back(mk(1, 1, 0, 30, 4, 2, 23));
    wr(0, 60);
    err_q.push_back(mk(1, 1, 0, 30, 4, 2, 23));
    wr(7, 1);
    err_q.push_back(mk(1, 1, 0, 30, 4, 2, 23));
    wr(3, 31);
    err_q.push_back(mk(1, 1, 0, 30, 4, 2, 23));
    wr(2, 24);
    step();
    check("ovf_sticky", bus.ovf, 1);

    // Write while busy is ignored.
    done_q.push_back(mk(2, 1, 0, 30, 4, 2, 23));
    err_q.push_back(mk(2, 1, 0, 30, 4, 2, 23));
    do_tick();
    wr(0, 5);
    wait_idle("busy_write");
    step();

    // Simultaneous write and tick: cascade sees the written value.
    done_q.push_back(mk(11, 1, 0, 30, 4, 2, 23));
    bus.tick = 1'b1; bus.set_en = 1'b1; bus.set_sel = 3'd0; bus.set_val = 6'd10;
    step();
    bus.tick = 1'b0; bus.set_en = 1'b0;
    check("simul_write_applied", bus.sec, 10);
    step();
    wait_idle("simul");
    step();

    // Reset while in HOUR: no done, reset values restored.
    wr(1, 59); wr(0, 59);
    do_tick();
    step(); step();
    clear = 1'b0;
    step();
    check_snap("midcascade_reset", cur(), mk(0, 0, 0, 1, 1, 6, 0));
    check("midcascade_busy", bus.busy, 0);
    check("midcascade_ovf", bus.ovf, 0);
    clear = 1'b1;
    step(); step(); step();

    check("done_queue_empty", done_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
